keypad_responder: RTL and testbench
===================================

KEYPAD_RESPONDER -- requirements
Module: keypad_responder

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000: clk cycles a key stays pressed once its column is strobed.
REQ-002 The block SHALL have parameter RELEASE_CYCLES, default 25000: clk cycles all rows stay low after a press, before done.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum clk cycles to wait for the target column strobe.
REQ-004 The block SHALL have port clk, input, 1: system clock.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, 1: key-press request valid.
REQ-007 The block SHALL have port req_key, input, 4: key code; 0-9 = digit, 10 = '*', 11 = '#'.
REQ-008 The block SHALL have port req_ready, output, 1: high only in IDLE.
REQ-009 The block SHALL have port key_col, input, 3: scanner column strobe, one-hot (001, 010, 100) or 000.
REQ-010 The block SHALL have port key_row, output, 4: emulated row return lines.
REQ-011 The block SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 The block SHALL have port done, output, 1: one-cycle pulse when a press/release sequence completes.
REQ-013 The block SHALL have port err_timeout, output, 1: one-cycle pulse when the column wait times out.
REQ-014 The block SHALL have port err_badkey, output, 1: one-cycle pulse when a request with req_key > 11 is accepted.

Function
REQ-015 Key map (column, row) SHALL be: col 001 -> 1:0001, 4:0010, 7:0100, *:1000; col 010 -> 2:0001, 5:0010, 8:0100, 0:1000; col 100 -> 3:0001, 6:0010, 9:0100, #:1000.
REQ-016 A request SHALL be accepted on a clk edge with req_valid && req_ready; on acceptance the target column and row mask SHALL be latched, and later changes to req_key SHALL be ignored.
REQ-017 The state machine SHALL have states IDLE, WAIT_COL, PRESS and RELEASE.
REQ-018 IDLE: on accepting a valid key, the next state SHALL be WAIT_COL with the cycle counter cleared.
REQ-019 IDLE: on accepting a key > 11, the block SHALL stay in IDLE and pulse err_badkey in the following cycle; done SHALL NOT pulse.
REQ-020 WAIT_COL: when key_col equals the latched column, the next state SHALL be PRESS with the counter cleared.
REQ-021 WAIT_COL: when the counter reaches TIMEOUT_CYCLES-1 without a match, the next state SHALL be IDLE with an err_timeout pulse.
REQ-022 PRESS: the counter SHALL increment every cycle; at HOLD_CYCLES-1 the next state SHALL be RELEASE with the counter cleared.
REQ-023 The PRESS hold time SHALL count in cycles even if key_col changes or goes to 000.
REQ-024 RELEASE: at RELEASE_CYCLES-1 the next state SHALL be IDLE, with done high in that same cycle.
REQ-025 key_row SHALL be combinational with zero latency: the latched row mask when state == PRESS and key_col equals the latched column, else 0000.
REQ-026 key_row SHALL have at most one bit set at any time.
REQ-027 The scanner halts on a nonzero row, so key_col is expected to hold during PRESS; REQ-025 SHALL still be applied every cycle.
REQ-028 The counter SHALL be 20 bits wide and SHALL NOT wrap within a state.
REQ-029 done, err_timeout and err_badkey SHALL be mutually exclusive and each exactly one cycle wide.

Reset
REQ-030 While rst is high, the block SHALL be in IDLE with counter 0, key_row 0000, busy 0, done 0, err_timeout 0, err_badkey 0, and req_ready 1 once rst deasserts.
REQ-031 Reset mid-PRESS SHALL force key_row to 0000 asynchronously, with no done pulse and the request discarded.

Verification
REQ-032 The bench SHALL cover: req_key=5 accepted, key_col cycling 001/010/100 and freezing at 010 -> key_row=0010 for exactly HOLD_CYCLES cycles, then 0000 for RELEASE_CYCLES, then done pulses once.
REQ-033 The bench SHALL cover: req_key=11 with key_col held at 001 -> no row driven until key_col=100, then key_row=1000.
REQ-034 The bench SHALL cover: req_key=13 -> err_badkey pulses one cycle, busy stays 0, key_row stays 0000.
REQ-035 The bench SHALL cover: req_key=1 with key_col held at 000 -> err_timeout after TIMEOUT_CYCLES cycles, then req_ready=1.
REQ-036 The bench SHALL cover: rst asserted 10 cycles into PRESS of key 0 -> key_row=0000 immediately, then IDLE and no done.
REQ-037 The bench SHALL cover: req_valid held high during busy -> no second acceptance until IDLE, then back-to-back presses 7 and 9 give rows 0100 then 0100 on columns 001 then 100.

Source files
------------

// File: rtl/keypad_responder_if.sv
// Bus between a keypad scanner/requester and keypad_responder.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_valid may be raised at any time. Once raised,
// req_valid/req_key should be held until the transfer edge. req_ready never
// depends on req_valid.
//
// Signals
//   req_valid   requester -> responder  key-press request valid
//   req_key     requester -> responder  key code (0-9 digit, 10 '*', 11 '#')
//   req_ready   responder -> requester  high only while idle
//   key_col     scanner   -> responder  column strobe, one-hot or 000
//   key_row     responder -> scanner    emulated row return lines
//   busy        responder -> requester  high whenever not idle
//   done        responder -> requester  1-cycle pulse, press/release complete
//   err_timeout responder -> requester  1-cycle pulse, column never strobed
//   err_badkey  responder -> requester  1-cycle pulse, key code > 11 accepted
//   dbg_state   responder -> observer   current FSM state encoding
interface keypad_responder_if;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_badkey;
  logic [1:0] dbg_state;

  modport master (
    output req_valid, req_key, key_col,
    input  req_ready, key_row, busy, done, err_timeout, err_badkey, dbg_state
  );

  modport slave (
    input  req_valid, req_key, key_col,
    output req_ready, key_row, busy, done, err_timeout, err_badkey, dbg_state
  );
endinterface

// File: rtl/keypad_responder.sv
// keypad_responder: emulates one key of a 3x4 matrix keypad being pressed.
// An accepted key code is mapped to a (column, row) pair. The block waits
// for the scanner to strobe that column, then returns the row bit while the
// column is strobed for HOLD_CYCLES clocks. It then keeps all rows low for
// RELEASE_CYCLES clocks and pulses done.
//
// Parameters
//   HOLD_CYCLES     cycles the key stays pressed once its column is strobed
//   RELEASE_CYCLES  cycles of all-rows-low after the press, before done
//   TIMEOUT_CYCLES  maximum cycles spent waiting for the column strobe
// Ports
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  keypad_responder_if.slave (request handshake, scanner lines, status)
module keypad_responder #(
  parameter int HOLD_CYCLES    = 50000,
  parameter int RELEASE_CYCLES = 25000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic               clk,
  input logic               rst,
  keypad_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_COL = 2'd1,
    S_PRESS    = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Terminal counts. The counter is cleared on every state entry and stops
  // at these values, so it never wraps inside a state.
  localparam logic [19:0] HOLD_LAST    = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0] RELEASE_LAST = 20'(RELEASE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [19:0] r_cnt;
  logic [2:0]  r_col;
  logic [3:0]  r_row;
  logic        r_done;
  logic        r_err_timeout;
  logic        r_err_badkey;

  logic        w_accept;
  logic        w_key_ok;
  logic        w_col_match;
  logic [2:0]  w_map_col;
  logic [3:0]  w_map_row;

  // Keypad matrix: columns left-to-right 001/010/100, rows top-to-bottom
  // 0001/0010/0100/1000.
  always_comb begin
    w_map_col = 3'b000;
    w_map_row = 4'b0000;
    w_key_ok  = 1'b1;
    case (bus.req_key)
      4'd1:    begin w_map_col = 3'b001; w_map_row = 4'b0001; end
      4'd2:    begin w_map_col = 3'b010; w_map_row = 4'b0001; end
      4'd3:    begin w_map_col = 3'b100; w_map_row = 4'b0001; end
      4'd4:    begin w_map_col = 3'b001; w_map_row = 4'b0010; end
      4'd5:    begin w_map_col = 3'b010; w_map_row = 4'b0010; end
      4'd6:    begin w_map_col = 3'b100; w_map_row = 4'b0010; end
      4'd7:    begin w_map_col = 3'b001; w_map_row = 4'b0100; end
      4'd8:    begin w_map_col = 3'b010; w_map_row = 4'b0100; end
      4'd9:    begin w_map_col = 3'b100; w_map_row = 4'b0100; end
      4'd10:   begin w_map_col = 3'b001; w_map_row = 4'b1000; end
      4'd0:    begin w_map_col = 3'b010; w_map_row = 4'b1000; end
      4'd11:   begin w_map_col = 3'b100; w_map_row = 4'b1000; end
      default: w_key_ok = 1'b0;
    endcase
  end

  assign w_accept    = bus.req_valid && (r_state == S_IDLE);
  assign w_col_match = (bus.key_col == r_col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 20'd0;
      r_col         <= 3'b000;
      r_row         <= 4'b0000;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_badkey  <= 1'b0;
    end else begin
      // Status flags are single-cycle pulses unless re-raised below.
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_badkey  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_key_ok) begin
              r_col   <= w_map_col;
              r_row   <= w_map_row;
              r_cnt   <= 20'd0;
              r_state <= S_WAIT_COL;
            end else begin
              // Unknown code: report it, keep waiting for a usable request.
              r_err_badkey <= 1'b1;
            end
          end
        end
        S_WAIT_COL: begin
          // A strobe on the final wait cycle still counts as a match.
          if (w_col_match) begin
            r_cnt   <= 20'd0;
            r_state <= S_PRESS;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cnt         <= 20'd0;
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_PRESS: begin
          // Hold time is wall-clock, independent of what key_col does.
          if (r_cnt == HOLD_LAST) begin
            r_cnt   <= 20'd0;
            r_state <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == RELEASE_LAST) begin
            r_cnt   <= 20'd0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        default: begin
          r_cnt   <= 20'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Row return is combinational so the scanner sees the key in the same
  // cycle it strobes the column. r_row is one-hot by construction. Reset
  // forces r_state to idle asynchronously, which drops the row at once.
  assign bus.key_row     = ((r_state == S_PRESS) && w_col_match) ? r_row : 4'b0000;
  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_badkey  = r_err_badkey;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_keypad_responder.sv
// Bench for keypad_responder with short hold/release/timeout settings.
// Inputs change only on falling clk edges. A compare process samples 1 ns
// later and checks every output against a countdown model of the key press.
// It then advances the model with the inputs the DUT will see at the next
// rising edge.
module tb_keypad_responder;
  localparam int HOLD    = 20;
  localparam int RELEASE = 10;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst;
  keypad_responder_if bus ();

  keypad_responder #(
    .HOLD_CYCLES   (HOLD),
    .RELEASE_CYCLES(RELEASE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want end earlier", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for column, 2 pressed, 3 released.
  // m_left counts cycles remaining in the phase.
  int         m_phase   = 0;
  int         m_left    = 0;
  logic [2:0] m_col     = 3'b000;
  logic [3:0] m_row     = 4'b0000;
  bit         m_done    = 0;
  bit         m_tmo     = 0;
  bit         m_bad     = 0;
  int         m_accepts = 0;

  // Observation counters, taken from the DUT outputs.
  int cyc          = 0;
  int cnt_done     = 0;
  int cnt_nonzero  = 0;
  int last_row_cyc = 0;
  int done_cyc     = 0;
  int cnt_rc[3][4];

  initial begin
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++) cnt_rc[c][r] = 0;
  end

  // Digits 1-9 fill the grid row by row; '*', 0 and '#' form the bottom row.
  function automatic void key_map(input int k, output logic [2:0] col, output logic [3:0] row);
    int c;
    int r;
    if (k == 0) begin c = 1; r = 3; end
    else if (k == 10) begin c = 0; r = 3; end
    else if (k == 11) begin c = 2; r = 3; end
    else begin c = (k - 1) % 3; r = (k - 1) / 3; end
    col = 3'(1 << c);
    row = 4'(1 << r);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [3:0] exp_row;
    bit n_done;
    bit n_tmo;
    bit n_bad;
    #1;
    cyc++;
    if (rst) begin
      m_phase = 0;
      m_done  = 0;
      m_tmo   = 0;
      m_bad   = 0;
    end
    exp_row = (m_phase == 2 && bus.key_col == m_col) ? m_row : 4'b0000;
    check("req_ready", int'(bus.req_ready), int'(m_phase == 0));
    check("busy", int'(bus.busy), int'(m_phase != 0));
    check("done", int'(bus.done), int'(m_done));
    check("err_timeout", int'(bus.err_timeout), int'(m_tmo));
    check("err_badkey", int'(bus.err_badkey), int'(m_bad));
    check("key_row", int'(bus.key_row), int'(exp_row));
    check("row_onehot", int'($countones(bus.key_row) <= 1), 1);
    check("pulse_excl", int'(bus.done) + int'(bus.err_timeout) + int'(bus.err_badkey) <= 1 ? 1 : 0, 1);

    if (bus.done) begin
      cnt_done++;
      done_cyc = cyc;
    end
    if (bus.key_row != 4'b0000) begin
      cnt_nonzero++;
      last_row_cyc = cyc;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 4; r++)
          if (bus.key_col[c] && bus.key_row[r]) cnt_rc[c][r]++;
    end

    n_done = 0;
    n_tmo  = 0;
    n_bad  = 0;
    if (!rst) begin
      case (m_phase)
        0: if (bus.req_valid) begin
             if (bus.req_key > 4'd11) n_bad = 1;
             else begin
               key_map(int'(bus.req_key), m_col, m_row);
               m_phase = 1;
               m_left  = TIMEOUT;
               m_accepts++;
             end
           end
        1: if (bus.key_col == m_col) begin
             m_phase = 2;
             m_left  = HOLD;
           end else begin
             m_left--;
             if (m_left == 0) begin m_phase = 0; n_tmo = 1; end
           end
        2: begin
             m_left--;
             if (m_left == 0) begin m_phase = 3; m_left = RELEASE; end
           end
        default: begin
             m_left--;
             if (m_left == 0) begin m_phase = 0; n_done = 1; end
           end
      endcase
    end
    m_done = n_done;
    m_tmo  = n_tmo;
    m_bad  = n_bad;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int key, input logic [2:0] col);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_key   = 4'(key);
    bus.key_col   = col;
  endtask

  // Returns at the falling edge where done is seen (inputs still drivable).
  task automatic wait_done(input int max, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < max);
    check(tag, int'(bus.done), 1);
  endtask

  function automatic logic [2:0] rand_col();
    case ($urandom_range(0, 3))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int snap_a;
    int snap_b;
    int snap_c;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_key   = 4'd0;
    bus.key_col   = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_key_row", int'(bus.key_row), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pulses", int'(bus.done) + int'(bus.err_timeout) + int'(bus.err_badkey), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(bus.req_ready), 1);

    // Key 5: column scan, then frozen on 010; req_key changes are ignored.
    snap_a = cnt_rc[1][1];
    snap_b = cnt_done;
    send(5, 3'b001);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_key   = 4'd3;
    bus.key_col   = 3'b100;
    @(negedge clk); bus.key_col = 3'b001;
    @(negedge clk); bus.key_col = 3'b100;
    @(negedge clk); bus.key_col = 3'b010;
    wait_done(200, "k5_done_seen");
    #2;
    check("k5_row_cycles", cnt_rc[1][1] - snap_a, HOLD);
    check("k5_done_count", cnt_done - snap_b, 1);
    check("k5_release_gap", done_cyc - last_row_cyc, RELEASE + 1);

    // Key '#': column 001 held, no row until 100 is strobed.
    send(11, 3'b001);
    snap_a = cnt_nonzero;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    check("k11_no_row_early", cnt_nonzero - snap_a, 0);
    @(negedge clk);
    bus.key_col = 3'b100;
    @(negedge clk);
    check("k11_row", int'(bus.key_row), 4'b1000);
    wait_done(100, "k11_done_seen");

    // Bad key 13
    send(13, 3'b000);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bad_pulse", int'(bus.err_badkey), 1);
    check("bad_busy", int'(bus.busy), 0);
    check("bad_row", int'(bus.key_row), 0);
    @(negedge clk);
    check("bad_pulse_width", int'(bus.err_badkey), 0);

    // Key 1 with no strobe: timeout
    send(1, 3'b000);
    n = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      n++;
    end while (!bus.err_timeout && n < 200);
    check("tmo_latency", n, TIMEOUT + 1);
    check("tmo_ready", int'(bus.req_ready), 1);

    // Key 0, reset 10 cycles into the press
    send(0, 3'b010);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.key_row == 4'b0000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("k0_row", int'(bus.key_row), 4'b1000);
    repeat (10) @(negedge clk);
    snap_b = cnt_done;
    #2;
    rst = 1'b1;
    #1;
    check("k0_rst_row", int'(bus.key_row), 0);
    check("k0_rst_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (HOLD + RELEASE + 10) @(negedge clk);
    #2;
    check("k0_no_done", cnt_done - snap_b, 0);
    check("k0_idle", int'(bus.req_ready), 1);

    // Valid held through busy, then back-to-back 7 and 9
    snap_a = cnt_rc[0][2];
    snap_b = cnt_rc[2][2];
    snap_c = m_accepts;
    send(7, 3'b001);
    wait_done(200, "k7_done_seen");
    bus.req_key = 4'd9;
    bus.key_col = 3'b100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_done(200, "k9_done_seen");
    #2;
    check("b2b_accepts", m_accepts - snap_c, 2);
    check("k7_row_cycles", cnt_rc[0][2] - snap_a, HOLD);
    check("k9_row_cycles", cnt_rc[2][2] - snap_b, HOLD);

    // Random traffic: requests, strobes and occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      bus.req_valid = ($urandom_range(0, 3) == 0);
      bus.req_key   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus.key_col = rand_col();
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
